// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM port between instruction fetch and load/store.
// MEM has priority. A multi-cycle strobe sequence is used, and each access returns a one-cycle ack.
//
// Ports:
//   clk, rst_n              : clock and async active-low reset
//   if_req/if_addr          : fetch request, held until if_ack
//   if_ack/if_rdata         : fetch ack pulse and instruction word
//   mem_req/we/byte/addr/wdata : load/store request, held until mem_ack
//   mem_ack/rdata/misalign  : load/store ack pulse, load data, misalign flag
//   busy                    : arbiter is not idle
//   sram_*                  : SRAM word address, data and active-low strobes
module mem_bus_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_byte,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ack,
    output logic [31:0]       mem_rdata,
    output logic              mem_misalign,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic [3:0]        sram_be_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_win, w_win_nxt;
    logic              r_we, w_we_nxt;
    logic              r_byte, w_byte_nxt;
    logic [1:0]        r_lane, w_lane_nxt;
    logic              r_if_ack, w_if_ack_nxt;
    logic [31:0]       r_if_rdata, w_if_rdata_nxt;
    logic              r_mem_ack, w_mem_ack_nxt;
    logic [31:0]       r_mem_rdata, w_mem_rdata_nxt;
    logic              r_misalign, w_misalign_nxt;
    logic              r_busy, w_busy_nxt;
    logic [ADDR_W-1:0] r_sram_addr, w_sram_addr_nxt;
    logic [31:0]       r_sram_wdata, w_sram_wdata_nxt;
    logic [3:0]        r_be_n, w_be_n_nxt;
    logic              r_ce_n, w_ce_n_nxt;
    logic              r_oe_n, w_oe_n_nxt;
    logic              r_we_n, w_we_n_nxt;

    logic [7:0]        w_lb_byte;
    logic              w_mis;
    logic              w_unused;

    // Fetch drops the low address bits; upper bits lie beyond the SRAM.
    assign w_unused = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                        mem_addr[31:ADDR_W+2]};

    assign w_mis = ~mem_byte & (mem_addr[1:0] != 2'b00);

    always_comb begin
        w_lb_byte = sram_rdata[7:0];
        unique case (r_lane)
            2'd0: w_lb_byte = sram_rdata[7:0];
            2'd1: w_lb_byte = sram_rdata[15:8];
            2'd2: w_lb_byte = sram_rdata[23:16];
            2'd3: w_lb_byte = sram_rdata[31:24];
            default: w_lb_byte = sram_rdata[7:0];
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_win_nxt        = r_win;
        w_we_nxt         = r_we;
        w_byte_nxt       = r_byte;
        w_lane_nxt       = r_lane;
        w_if_ack_nxt     = 1'b0;
        w_if_rdata_nxt   = r_if_rdata;
        w_mem_ack_nxt    = 1'b0;
        w_mem_rdata_nxt  = r_mem_rdata;
        w_misalign_nxt   = 1'b0;
        w_sram_addr_nxt  = r_sram_addr;
        w_sram_wdata_nxt = r_sram_wdata;
        w_be_n_nxt       = 4'hF;
        w_ce_n_nxt       = 1'b1;
        w_oe_n_nxt       = 1'b1;
        w_we_n_nxt       = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                if (mem_req) begin
                    w_win_nxt  = 1'b1;
                    w_we_nxt   = mem_we;
                    w_byte_nxt = mem_byte;
                    w_lane_nxt = mem_addr[1:0];
                    if (w_mis) begin
                        w_state_nxt     = S_DONE;
                        w_mem_ack_nxt   = 1'b1;
                        w_misalign_nxt  = 1'b1;
                        w_mem_rdata_nxt = '0;
                    end else begin
                        w_state_nxt      = S_ACCESS;
                        w_cnt_nxt        = CNT_INIT;
                        w_sram_addr_nxt  = mem_addr[ADDR_W+1:2];
                        w_sram_wdata_nxt = mem_byte ? {4{mem_wdata[7:0]}}
                                                    : mem_wdata;
                        w_be_n_nxt       = mem_byte
                                         ? ~(4'b0001 << mem_addr[1:0])
                                         : 4'b0000;
                        w_ce_n_nxt       = 1'b0;
                        w_oe_n_nxt       = mem_we;
                        w_we_n_nxt       = ~mem_we;
                    end
                end else if (if_req) begin
                    w_win_nxt        = 1'b0;
                    w_we_nxt         = 1'b0;
                    w_byte_nxt       = 1'b0;
                    w_lane_nxt       = 2'd0;
                    w_state_nxt      = S_ACCESS;
                    w_cnt_nxt        = CNT_INIT;
                    w_sram_addr_nxt  = if_addr[ADDR_W+1:2];
                    w_sram_wdata_nxt = '0;
                    w_be_n_nxt       = 4'b0000;
                    w_ce_n_nxt       = 1'b0;
                    w_oe_n_nxt       = 1'b0;
                end
            end
            S_ACCESS: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt  = r_cnt - 4'd1;
                    w_be_n_nxt = r_be_n;
                    w_ce_n_nxt = 1'b0;
                    w_oe_n_nxt = r_we;
                    // Release we_n one cycle early so data is held.
                    w_we_n_nxt = ~(r_we & (r_cnt != 4'd1));
                end else begin
                    w_state_nxt = S_DONE;
                    if (r_win) begin
                        w_mem_ack_nxt = 1'b1;
                        if (r_we) begin
                            w_mem_rdata_nxt = '0;
                        end else if (r_byte) begin
                            w_mem_rdata_nxt = {{24{w_lb_byte[7]}}, w_lb_byte};
                        end else begin
                            w_mem_rdata_nxt = sram_rdata;
                        end
                    end else begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = sram_rdata;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_win        <= 1'b0;
            r_we         <= 1'b0;
            r_byte       <= 1'b0;
            r_lane       <= '0;
            r_if_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_ack    <= 1'b0;
            r_mem_rdata  <= '0;
            r_misalign   <= 1'b0;
            r_busy       <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_be_n       <= 4'hF;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_win        <= w_win_nxt;
            r_we         <= w_we_nxt;
            r_byte       <= w_byte_nxt;
            r_lane       <= w_lane_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_mem_ack    <= w_mem_ack_nxt;
            r_mem_rdata  <= w_mem_rdata_nxt;
            r_misalign   <= w_misalign_nxt;
            r_busy       <= w_busy_nxt;
            r_sram_addr  <= w_sram_addr_nxt;
            r_sram_wdata <= w_sram_wdata_nxt;
            r_be_n       <= w_be_n_nxt;
            r_ce_n       <= w_ce_n_nxt;
            r_oe_n       <= w_oe_n_nxt;
            r_we_n       <= w_we_n_nxt;
        end
    end

    assign if_ack       = r_if_ack;
    assign if_rdata     = r_if_rdata;
    assign mem_ack      = r_mem_ack;
    assign mem_rdata    = r_mem_rdata;
    assign mem_misalign = r_misalign;
    assign busy         = r_busy;
    assign sram_addr    = r_sram_addr;
    assign sram_wdata   = r_sram_wdata;
    assign sram_be_n    = r_be_n;
    assign sram_ce_n    = r_ce_n;
    assign sram_oe_n    = r_oe_n;
    assign sram_we_n    = r_we_n;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: SRAM model plus transaction-level golden memory.
// A second instance with WAIT_CYCLES=4 exercises back-to-back fetch throughput.
module tb_mem_bus_arbiter;

    localparam int W  = 2;
    localparam int W2 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 0 (WAIT_CYCLES = 2)
    logic        if_req, if_ack, mem_req, mem_we, mem_byte, mem_ack;
    logic        mem_misalign, busy, ce_n, oe_n, we_n;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] sram_wdata, sram_rdata;
    logic [19:0] sram_addr;
    logic [3:0]  be_n;

    // DUT 1 (WAIT_CYCLES = 4), fetch only
    logic        if_req2, if_ack2, mem_req2, mem_we2, mem_byte2, mem_ack2;
    logic        mem_misalign2, busy2, ce_n2, oe_n2, we_n2;
    logic [31:0] if_addr2, if_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
    logic [31:0] sram_wdata2, sram_rdata2;
    logic [19:0] sram_addr2;
    logic [3:0]  be_n2;

    mem_bus_arbiter #(.ADDR_W(20), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_misalign(mem_misalign), .busy(busy),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_be_n(be_n),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
    );

    mem_bus_arbiter #(.ADDR_W(20), .WAIT_CYCLES(W2)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2),
        .if_rdata(if_rdata2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_byte(mem_byte2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ack(mem_ack2),
        .mem_rdata(mem_rdata2), .mem_misalign(mem_misalign2), .busy(busy2),
        .sram_addr(sram_addr2), .sram_wdata(sram_wdata2),
        .sram_rdata(sram_rdata2), .sram_be_n(be_n2),
        .sram_ce_n(ce_n2), .sram_oe_n(oe_n2), .sram_we_n(we_n2)
    );

    // SRAM model (256 words) and golden memory
    logic [31:0] sm [256];
    logic [31:0] gm [256];
    logic        p_en  = 1'b0;
    logic [7:0]  p_idx = '0;
    logic [31:0] p_val = '0;

    assign sram_rdata  = (sram_addr < 20'd256) ? sm[sram_addr[7:0]]
                                               : 32'hDEAD_BEEF;
    assign sram_rdata2 = (sram_addr2 < 20'd256) ? sm[sram_addr2[7:0]]
                                                : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (p_en) begin
            sm[p_idx] <= p_val;
        end else if (!ce_n && !we_n && sram_addr < 20'd256) begin
            for (int i = 0; i < 4; i++)
                if (!be_n[i])
                    sm[sram_addr[7:0]][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        p_en = 1'b1; p_idx = idx[7:0]; p_val = v; gm[idx] = v;
        @(negedge clk);
        p_en = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic bt,
                          input logic [31:0] a, input logic [31:0] wd);
        int          n, ce_c, oe_c, we_c, idx;
        logic        mis, got, other, mg;
        logic [1:0]  ln;
        logic [3:0]  ebe, sbe;
        logic [7:0]  bv;
        logic [19:0] sa;
        logic [31:0] ewd, erd, w, swd, rd, prev_if;
        idx = int'(a[9:2]);
        ln  = a[1:0];
        mis = !bt && (a[1:0] != 2'b00);
        ebe = bt ? ~(4'b0001 << ln) : 4'b0000;
        ewd = bt ? {4{wd[7:0]}} : wd;
        w   = gm[idx];
        bv  = w[8*ln +: 8];
        erd = mis ? 32'h0 : (bt ? {{24{bv[7]}}, bv} : w);
        n = 0; ce_c = 0; oe_c = 0; we_c = 0;
        got = 0; other = 0; mg = 0;
        sa = '0; sbe = '0; swd = '0; rd = '0;
        @(negedge clk);
        chk("busy_idle", busy, 0);
        prev_if  = if_rdata;
        mem_req  = 1'b1; mem_we = we; mem_byte = bt;
        mem_addr = a; mem_wdata = wd;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (!ce_n) begin
                ce_c++; sa = sram_addr; sbe = be_n; swd = sram_wdata;
            end
            if (!oe_n) oe_c++;
            if (!we_n) we_c++;
            if (if_ack) other = 1;
            if (mem_ack) begin
                got = 1; rd = mem_rdata; mg = mem_misalign;
            end else if (n == 1) begin
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_we    = ~mem_we;
                mem_byte  = ~mem_byte;
            end
        end
        mem_req = 1'b0;
        last_rd = rd;
        chk("mem_lat", n, mis ? 1 : W + 1);
        chk("misalign", mg, mis);
        if (!we || mis) chk("mem_rdata", rd, erd);
        chk("ce_cnt", ce_c, mis ? 0 : W);
        chk("oe_cnt", oe_c, (mis || we) ? 0 : W);
        chk("we_cnt", we_c, (!mis && we) ? W - 1 : 0);
        if (!mis) begin
            chk("sram_addr", 32'(sa), 32'(a[21:2]));
            chk("be_n", 32'(sbe), 32'(ebe));
        end
        if (!mis && we) chk("sram_wdata", swd, ewd);
        chk("if_ack_quiet", other, 0);
        chk("if_rdata_hold", if_rdata, prev_if);
        if (we && !mis) begin
            for (int i = 0; i < 4; i++)
                if (!ebe[i]) w[8*i +: 8] = ewd[8*i +: 8];
            gm[idx] = w;
        end
    endtask

    task automatic do_if(input logic [31:0] a);
        int          n, ce_c, oe_c, we_c;
        logic        got, other;
        logic [3:0]  sbe;
        logic [19:0] sa;
        logic [31:0] erd, rd, prev_mem;
        erd = gm[int'(a[9:2])];
        n = 0; ce_c = 0; oe_c = 0; we_c = 0;
        got = 0; other = 0; sa = '0; sbe = '0; rd = '0;
        @(negedge clk);
        chk("busy_idle", busy, 0);
        prev_mem = mem_rdata;
        if_req   = 1'b1; if_addr = a;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (!ce_n) begin ce_c++; sa = sram_addr; sbe = be_n; end
            if (!oe_n) oe_c++;
            if (!we_n) we_c++;
            if (mem_ack) other = 1;
            if (if_ack) begin
                got = 1; rd = if_rdata;
            end else if (n == 1) begin
                if_addr = $urandom;
            end
        end
        if_req  = 1'b0;
        last_rd = rd;
        chk("if_lat", n, W + 1);
        chk("if_rdata", rd, erd);
        chk("if_ce_cnt", ce_c, W);
        chk("if_oe_cnt", oe_c, W);
        chk("if_we_cnt", we_c, 0);
        chk("if_sram_addr", 32'(sa), 32'(a[21:2]));
        chk("if_be_n", 32'(sbe), 32'h0);
        chk("mem_ack_quiet", other, 0);
        chk("mem_rdata_hold", mem_rdata, prev_mem);
    endtask

    initial begin
        int          n, ma, ia, k, acks, bl, tprev;
        logic        seen;
        logic [19:0] a1, a2;
        logic [31:0] mrd, ird, a, cur2;

        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_byte = 0;
        mem_addr = 0; mem_wdata = 0;
        if_req2 = 0; if_addr2 = 0; mem_req2 = 0; mem_we2 = 0;
        mem_byte2 = 0; mem_addr2 = 0; mem_wdata2 = 0;

        // reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_strobes", {ce_n, oe_n, we_n}, 3'b111);
        chk("rst_be_n", be_n, 4'hF);
        chk("rst_acks", {if_ack, mem_ack, mem_misalign}, 3'b000);
        chk("rst_busy", busy, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_sram_addr", 32'(sram_addr), 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // preload both memories with the same random contents
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            p_en = 1'b1; p_idx = 8'(i); p_val = $urandom; gm[i] = p_val;
        end
        @(negedge clk);
        p_en = 1'b0;

        // directed: fetch at 0x104
        poke(32'h41, 32'h2402_0005);
        do_if(32'h0000_0104);
        chk("fetch_104", last_rd, 32'h2402_0005);

        // directed: LB sign extension
        poke(4, 32'h80FF_FF7F);
        do_mem(0, 1, 32'h13, 32'h0);
        chk("lb_13", last_rd, 32'hFFFF_FF80);
        do_mem(0, 1, 32'h10, 32'h0);
        chk("lb_10", last_rd, 32'h0000_007F);

        // directed: simultaneous requests, MEM wins
        @(negedge clk);
        mem_req = 1; mem_we = 0; mem_byte = 0; mem_addr = 32'h10;
        if_req = 1; if_addr = 32'h20;
        n = 0; ma = -1; ia = -1; a1 = '0; a2 = '0; mrd = '0; ird = '0;
        while ((ma < 0 || ia < 0) && n < 40) begin
            @(negedge clk);
            n++;
            if (!ce_n) begin
                if (ma < 0) a1 = sram_addr;
                else a2 = sram_addr;
            end
            if (mem_ack) begin ma = n; mrd = mem_rdata; mem_req = 0; end
            if (if_ack) begin ia = n; ird = if_rdata; if_req = 0; end
        end
        mem_req = 0; if_req = 0;
        chk("both_mem_lat", ma, W + 1);
        chk("both_if_lat", ia, 2 * W + 3);
        chk("both_addr1", 32'(a1), 32'h4);
        chk("both_addr2", 32'(a2), 32'h8);
        chk("both_mem_rd", mrd, gm[4]);
        chk("both_if_rd", ird, gm[8]);

        // directed: SB lanes and misaligned SW
        do_mem(1, 1, 32'h22, 32'h0000_00AB);
        do_mem(1, 0, 32'h22, 32'h1234_5678);
        do_mem(0, 0, 32'h20, 32'h0);

        // async reset in the middle of a store (same data, memory intact)
        @(negedge clk);
        mem_req = 1; mem_we = 1; mem_byte = 0; mem_addr = 32'h30;
        mem_wdata = gm[12];
        n = 0;
        while (we_n && n < 10) begin @(negedge clk); n++; end
        chk("rst_we_seen", we_n, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_strobes", {ce_n, oe_n, we_n}, 3'b111);
        chk("arst_be_n", be_n, 4'hF);
        chk("arst_busy", busy, 0);
        mem_req = 0;
        seen = mem_ack;
        repeat (2) begin @(negedge clk); seen = seen | mem_ack; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); seen = seen | mem_ack; end
        chk("arst_no_ack", seen, 0);
        chk("arst_idle", busy, 0);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 1023));
            case (k)
                0, 1, 2: do_if(a);
                3, 8:    do_mem(0, 0, {a[31:2], 2'b00}, 32'h0);
                4:       do_mem(1, 0, {a[31:2], 2'b00}, $urandom);
                5:       do_mem(0, 1, a, 32'h0);
                6, 9:    do_mem(1, 1, a, $urandom);
                default: do_mem($urandom_range(0, 1) == 1, 0,
                                {a[31:2], 2'($urandom_range(1, 3))},
                                $urandom);
            endcase
        end
        // read back a sweep so every stored word gets compared
        for (int i = 0; i < 16; i++) do_mem(0, 0, 32'(i * 64), 32'h0);

        // WAIT_CYCLES=4: back-to-back fetches
        @(negedge clk);
        cur2 = 32'($urandom_range(0, 1023));
        if_req2 = 1; if_addr2 = cur2;
        n = 0; acks = 0; bl = 0; tprev = 0;
        while (acks < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (if_ack2) begin
                acks++;
                chk("b2b_rdata", if_rdata2, gm[int'(cur2[9:2])]);
                if (acks == 1) chk("b2b_lat", n, W2 + 1);
                else begin
                    chk("b2b_gap", cyc - tprev, W2 + 2);
                    chk("b2b_busy_low", bl, 1);
                end
                tprev = cyc;
                bl = 0;
                if_req2 = 0;
            end else if (!busy2) begin
                bl++;
                if (!if_req2) begin
                    cur2 = 32'($urandom_range(0, 1023));
                    if_req2 = 1; if_addr2 = cur2;
                end
            end
        end
        if_req2 = 0;
        chk("b2b_acks", acks, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences the single shared SRAM port between instruction fetch (IF) and the load/store stage (MEM).
- The load/store stage is driven by the decoder's IO mode (LB/LW/SB/SW).
- Arbitrates the two requesters and runs a multi-cycle SRAM strobe sequence.
- Handles byte lanes and sign extension, and returns data with a one-cycle acknowledge pulse.

Parameters:
- ADDR_W, 20: SRAM word-address width; sram_addr = byte_addr[ADDR_W+1:2].
- WAIT_CYCLES, 2: cycles the SRAM strobes are held per access; legal range 2..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle
- if_rdata  out  32  fetched instruction word
- mem_req  in  1  load/store request; held until mem_ack
- mem_we  in  1  1 = store, 0 = load
- mem_byte  in  1  1 = byte access (LB/SB), 0 = word access (LW/SW)
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data; bits [7:0] used for SB
- mem_ack  out  1  one-cycle pulse; mem_rdata/mem_misalign valid in the same cycle
- mem_rdata  out  32  load result; LB result sign-extended
- mem_misalign  out  1  word access with addr[1:0] != 0; no SRAM cycle performed
- busy  out  1  state != IDLE
- sram_addr  out  ADDR_W  word address
- sram_wdata  out  32  write data
- sram_rdata  in  32  read data
- sram_be_n  out  4  byte enables, active low
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  strobes, active low

Behaviour:
Reset (async, rst_n=0):
- State = IDLE; all strobes and sram_be_n = 1; acks, misalign and busy = 0; rdata outputs, sram_addr and sram_wdata = 0.
- Any in-flight access is abandoned; requesters must re-issue after reset.

All outputs are registered.

FSM states:
- IDLE:
  - Sample requests. mem_req has priority over if_req.
  - On grant, latch address/we/byte/wdata and the winner id.
  - A misaligned MEM word request goes to DONE with misalign = 1.
  - Any other granted request goes to ACCESS with cnt = WAIT_CYCLES-1.
  - No request: stay in IDLE.
- ACCESS:
  - ce_n = 0 throughout; be_n per lane rules below.
  - Read: oe_n = 0.
  - Write: we_n = 0 except in the final ACCESS cycle (cnt == 0), which gives data hold; sram_wdata driven throughout.
  - cnt decrements each cycle; at cnt == 0, register read data and go to DONE.
- DONE:
  - Pulse the winner's ack for exactly one cycle with data; strobes = 1; next state IDLE.
  - req is not sampled in DONE.
  - The requester may present a new request in the cycle after its ack; that request is sampled in IDLE.

Latency:
- Request first seen in IDLE at cycle N gives ack at cycle N+WAIT_CYCLES+1.
- A misaligned request gives ack at N+1.
- Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.

Lane rules:
- Word access: be_n = 4'b0000.
- Byte access: lane = addr[1:0]; be_n has only that lane's bit low.
- SB: sram_wdata = {4{wdata[7:0]}}.
- LB: mem_rdata = sign-extended sram_rdata byte of that lane.

Misalign:
- For a misaligned word access: mem_rdata = 0, mem_misalign = 1, memory unchanged.
- mem_misalign = 0 on every other ack.
- IF never misaligns: addr[1:0] is dropped.

Simultaneous and boundary cases:
- Both requests in IDLE: MEM served first; IF is served on the next IDLE visit. IF is not starved, because MEM issues at most one request per instruction.
- Requester inputs changing mid-access are ignored; latched values are used.
- The ack of the non-winner stays 0.
- The winner's rdata output holds its value until that winner's next ack.

Test Plan:
- Reset during an ACCESS write at WAIT_CYCLES=2 → strobes go high immediately (async), no ack; after release, IDLE and busy = 0.
- if_req, addr 0x0000_0104, sram_rdata 0x2402_0005 → sram_addr = 0x41, oe_n low for 2 cycles, if_ack at N+3 with if_rdata = 0x2402_0005.
- mem_req and if_req asserted in the same cycle (LW addr 0x10, fetch 0x20) → mem_ack at N+3, then if_ack at N+7; sram_addr = 0x4 then 0x8.
- LB at addr 0x13 with sram_rdata 0x80FF_FF7F → be_n = 4'b0111, mem_rdata = 0xFFFF_FF80. LB at 0x10 → mem_rdata = 0x0000_007F.
- SB at addr 0x22, wdata 0x0000_00AB → be_n = 4'b1011, sram_wdata = 0xABAB_ABAB, we_n low 1 cycle out of a 2-cycle ce_n window. SW at 0x22 → mem_ack at N+1, mem_misalign = 1, ce_n never asserted.
- WAIT_CYCLES=4 with back-to-back IF requests (next request presented the cycle after ack) → acks exactly 6 cycles apart, busy low exactly 1 cycle between accesses.
